matrix_capture: RTL and testbench
=================================

// Module: matrix_capture
// PURPOSE
// - Receive end of the 74HC595 LED-matrix serial link (shift clock, latch, MOSI); same 32-bit word per row that the matrix driver sends.
// - Deserialises words, decodes the one-hot row anode and active-low R/B/G bytes, and accumulates colour planes over 3 frames.
// - Publishes the reconstructed 8x8 0bxRGB image as 8 Wishbone-readable row registers.
// - Used as an on-board loopback monitor and as the driver's check partner in simulation.
// PARAMETERS
// - WB_DATA_WIDTH   32  Wishbone data width; one row = 8 nibbles.
// - WB_ADDR_WIDTH   4   Register address: rows 0-7, STATUS 8, CTRL 9.
// - SYNC_STAGES     2   Synchroniser depth on the three serial inputs.
// PORTS
// - clk             in   1   System clock.
// - reset           in   1   Synchronous, active-high.
// - i_ser_clk       in   1   Shift clock; may be asynchronous to clk.
// - i_ser_latch     in   1   Latch/CE.
// - i_ser_mosi      in   1   Serial data.
// - i_wb_cyc/i_wb_stb/i_wb_we   in  1  Wishbone pipelined slave controls.
// - i_wb_addr       in   WB_ADDR_WIDTH  Register address.
// - i_wb_sel        in   WB_DATA_WIDTH/8  Byte selects; used for CTRL only.
// - i_wb_wdata      in   WB_DATA_WIDTH  Write data.
// - o_wb_ack        out  1   Ack, 1 cycle after an accepted strobe.
// - o_wb_stall      out  1   Tied 0.
// - o_wb_rdata      out  WB_DATA_WIDTH  Registered read data.
// - o_frame_strobe  out  1   1-cycle pulse when the visible image is updated.
// BEHAVIOUR
// - Input sync: all three inputs pass through SYNC_STAGES flops, then one edge-detect flop.
//   - Serial clock high and low phases must each be >= 3 clk cycles.
// - Shift: on a synced i_ser_clk rise, shreg <= {shreg[30:0], mosi_sync}; bitcnt += 1, saturating at 63.
//   - The first bit sent ends in shreg[31].
// - Word layout at latch:
//   - [31:24] red, col0 in bit 31.
//   - [23:16] blue.
//   - [15:8] green.
//   - Colours are active-low: 0 = on.
//   - [7:0] anode: row r in bit 7-r, active-high.
// - Latch: on a synced i_ser_latch rise, the word is valid iff bitcnt==32 and the anode byte is exactly one-hot.
//   - Valid word: accum[row] |= colour nibbles.
//   - Col c nibble sits at bits [4*(7-c)+3 : 4*(7-c)] = {0,R,G,B}.
//   - bitcnt always clears on a latch rise.
//   - Bad bitcnt: frame_err_cnt += 1, word dropped.
//   - Anode not one-hot, bitcnt OK: row_err_cnt += 1, word dropped.
//   - Both error counts are 8 bits and saturate at 0xFF.
// - Shift and latch rise in the same cycle:
//   - The shift is discarded.
//   - Latch handling uses the pre-shift shreg and bitcnt.
// - Frames: a valid latch of row 7 ends a frame; frame_cnt is 16 bits and wraps.
//   - Every 3rd frame end (mod-3 counter 2->0): visible[0..7] <= accum, accum <= 0, o_frame_strobe = 1 the next cycle.
//   - The row-7 OR from that same word is included in the copy.
// - Wishbone:
//   - Accept when cyc&&stb; ack next cycle; never stall.
//   - Read addr 0-7 -> visible[addr]; a read colliding with a copy returns the pre-copy value.
//   - Read 8 (STATUS) -> {frame_cnt[15:0], row_err_cnt, frame_err_cnt}.
//   - Read 9 -> 0; reads of 10-15 -> 0.
//   - Write 9 with sel[0] && wdata[0] -> clears accum, both error counts, the mod-3 counter and bitcnt; frame_cnt is kept.
//   - Other writes are acked and ignored.
// - Reset: all state and buffers 0; o_wb_ack=0, o_wb_rdata=0, o_frame_strobe=0.
//   - Sync flops are cleared, so no false edge after reset; mid-word reset drops the partial word.
// TESTING
// - Image capture: 3 frames of 8 rows; each row word 0x7FFFFF00|(1<<(7-r)) (red col0 on).
//   -> Every row reads 0x40000000; one o_frame_strobe after the 24th latch.
// - RGB over 3 frames: row2 red col0 in frame0, blue col0 in frame1, green col0 in frame2; all other words blank.
//   -> Row2 reads 0x70000000; other rows read 0.
// - Short word: 31 shifts then latch -> STATUS[7:0]=1, accum unchanged; the next 32-bit word is accepted.
// - Bad anode: anode byte 0x00, then 0x81 -> STATUS[15:8]=2; frame_cnt not advanced.
// - Collision and control:
//   - Shift and latch rise on the same cycle -> shift ignored.
//   - CTRL write 0x1 mid-frame -> error counts 0; next visible update only after 3 complete frames.
// - Reset mid-word: assert reset after 17 shifts -> all registers 0; a clean 32-bit word then latches correctly.

Source files
------------

// File: rtl/matrix_capture.sv
// matrix_capture
//   Receive end of the 74HC595 LED-matrix serial link. Serial words are
//   deserialised and decoded into a one-hot row anode plus active-low R/B/G
//   column bytes. Colour planes are ORed into an accumulator over three frames,
//   and the result is published as eight Wishbone-readable row registers.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   i_ser_clk             serial shift clock (may be asynchronous to clk)
//   i_ser_latch           serial latch / CE
//   i_ser_mosi            serial data
//   i_wb_cyc/stb/we       Wishbone pipelined slave controls
//   i_wb_addr             0-7 rows, 8 STATUS, 9 CTRL
//   i_wb_sel              byte selects (CTRL only)
//   i_wb_wdata            write data
//   o_wb_ack              ack one cycle after an accepted strobe
//   o_wb_stall            always 0
//   o_wb_rdata            registered read data
//   o_frame_strobe        one-cycle pulse when the visible image is updated
module matrix_capture #(
  parameter int WB_DATA_WIDTH = 32,
  parameter int WB_ADDR_WIDTH = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_ser_clk,
  input  logic                       i_ser_latch,
  input  logic                       i_ser_mosi,
  input  logic                       i_wb_cyc,
  input  logic                       i_wb_stb,
  input  logic                       i_wb_we,
  input  logic [WB_ADDR_WIDTH-1:0]   i_wb_addr,
  input  logic [WB_DATA_WIDTH/8-1:0] i_wb_sel,
  input  logic [WB_DATA_WIDTH-1:0]   i_wb_wdata,
  output logic                       o_wb_ack,
  output logic                       o_wb_stall,
  output logic [WB_DATA_WIDTH-1:0]   o_wb_rdata,
  output logic                       o_frame_strobe
);

  // ---------------------------------------------------------------------------
  // Input synchronisers: bit 2 = ser_clk, bit 1 = latch, bit 0 = mosi
  // ---------------------------------------------------------------------------
  logic [2:0]  r_sync [SYNC_STAGES];
  logic [1:0]  r_edge_prev;
  logic [2:0]  w_sync_out;
  logic        w_clk_rise;
  logic        w_lat_rise;
  logic        w_mosi;

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_clk_rise = w_sync_out[2] & ~r_edge_prev[1];
  assign w_lat_rise = w_sync_out[1] & ~r_edge_prev[0];
  assign w_mosi     = w_sync_out[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_edge_prev <= '0;
    end else begin
      r_sync[0] <= {i_ser_clk, i_ser_latch, i_ser_mosi};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_edge_prev <= w_sync_out[2:1];
    end
  end

  // ---------------------------------------------------------------------------
  // Capture state
  // ---------------------------------------------------------------------------
  logic [31:0] r_shreg;
  logic [5:0]  r_bitcnt;
  logic [31:0] r_accum   [8];
  logic [31:0] r_visible [8];
  logic [7:0]  r_frame_err;
  logic [7:0]  r_row_err;
  logic [15:0] r_frame_cnt;
  logic [1:0]  r_mod3;
  logic        r_frame_strobe;

  // ---------------------------------------------------------------------------
  // Word decode (always from the pre-shift register contents)
  // ---------------------------------------------------------------------------
  logic [7:0]  w_anode;
  logic        w_onehot;
  logic        w_bit_ok;
  logic        w_word_ok;
  logic [2:0]  w_row;
  logic [31:0] w_nib;
  logic        w_frame_end;
  logic        w_copy;

  assign w_anode     = r_shreg[7:0];
  assign w_onehot    = (w_anode != 8'h00) && ((w_anode & (w_anode - 8'h01)) == 8'h00);
  assign w_bit_ok    = (r_bitcnt == 6'd32);
  assign w_word_ok   = w_bit_ok && w_onehot;
  assign w_frame_end = w_word_ok && (w_row == 3'd7);
  assign w_copy      = w_frame_end && (r_mod3 == 2'd2);

  always_comb begin
    w_row = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (w_anode[7-i]) w_row = 3'(i);
    end
  end

  // Column c nibble = {0, R, G, B}, colours inverted from active-low bytes.
  always_comb begin
    w_nib = '0;
    for (int unsigned c = 0; c < 8; c++) begin
      w_nib[4*(7-c) +: 4] = {1'b0, ~r_shreg[31-c], ~r_shreg[15-c], ~r_shreg[23-c]};
    end
  end

  // ---------------------------------------------------------------------------
  // Wishbone decode
  // ---------------------------------------------------------------------------
  logic        w_accept;
  logic        w_ctrl_clear;
  logic [31:0] w_rdata;
  logic        r_ack;
  logic [WB_DATA_WIDTH-1:0] r_rdata;
  logic        w_unused;

  assign w_accept     = i_wb_cyc && i_wb_stb;
  assign w_ctrl_clear = w_accept && i_wb_we && (i_wb_addr == WB_ADDR_WIDTH'(9))
                        && i_wb_sel[0] && i_wb_wdata[0];
  assign w_unused     = ^{i_wb_sel, i_wb_wdata};

  always_comb begin
    w_rdata = '0;
    if (i_wb_addr < WB_ADDR_WIDTH'(8)) begin
      w_rdata = r_visible[i_wb_addr[2:0]];
    end else if (i_wb_addr == WB_ADDR_WIDTH'(8)) begin
      w_rdata = {r_frame_cnt, r_row_err, r_frame_err};
    end
  end

  // ---------------------------------------------------------------------------
  // Shift / latch / frame bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg        <= '0;
      r_bitcnt       <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        r_accum[i]   <= '0;
        r_visible[i] <= '0;
      end
      r_frame_err    <= '0;
      r_row_err      <= '0;
      r_frame_cnt    <= '0;
      r_mod3         <= '0;
      r_frame_strobe <= 1'b0;
    end else begin
      r_frame_strobe <= 1'b0;
      if (w_ctrl_clear) begin
        // A CTRL clear wins over any serial event in the same cycle.
        for (int unsigned i = 0; i < 8; i++) r_accum[i] <= '0;
        r_frame_err <= '0;
        r_row_err   <= '0;
        r_mod3      <= '0;
        r_bitcnt    <= '0;
      end else if (w_lat_rise) begin
        // A coincident shift edge is dropped; decode uses the pre-shift word.
        r_bitcnt <= '0;
        if (!w_bit_ok) begin
          if (r_frame_err != 8'hFF) r_frame_err <= r_frame_err + 8'd1;
        end else if (!w_onehot) begin
          if (r_row_err != 8'hFF) r_row_err <= r_row_err + 8'd1;
        end else if (w_copy) begin
          // Third frame end: publish accum including this row-7 word.
          for (int unsigned i = 0; i < 8; i++) begin
            r_visible[i] <= (3'(i) == w_row) ? (r_accum[i] | w_nib) : r_accum[i];
            r_accum[i]   <= '0;
          end
          r_frame_strobe <= 1'b1;
          r_frame_cnt    <= r_frame_cnt + 16'd1;
          r_mod3         <= 2'd0;
        end else begin
          r_accum[w_row] <= r_accum[w_row] | w_nib;
          if (w_frame_end) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_mod3      <= r_mod3 + 2'd1;
          end
        end
      end else if (w_clk_rise) begin
        r_shreg <= {r_shreg[30:0], w_mosi};
        if (r_bitcnt != 6'd63) r_bitcnt <= r_bitcnt + 6'd1;
      end
    end
  end

  // Read data registers the pre-update visible[] when a copy lands the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= w_accept;
      if (w_accept) begin
        r_rdata <= i_wb_we ? '0 : WB_DATA_WIDTH'(w_rdata);
      end
    end
  end

  assign o_wb_ack       = r_ack;
  assign o_wb_stall     = 1'b0;
  assign o_wb_rdata     = r_rdata;
  assign o_frame_strobe = r_frame_strobe;

endmodule

// File: tb/tb_matrix_capture.sv
// tb_matrix_capture
//   Directed bench for matrix_capture: bit-bangs the serial link, reads the
//   row and STATUS registers over Wishbone, and compares against hand-computed
//   constants, partly from a {address, expected} table.
module tb_matrix_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        ser_clk, ser_latch, ser_mosi;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_addr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_wdata;
  logic        wb_ack, wb_stall;
  logic [31:0] wb_rdata;
  logic        frame_strobe;

  int total = 0;
  int bad   = 0;
  int strobe_cnt = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[12];

  matrix_capture #(
    .WB_DATA_WIDTH(32),
    .WB_ADDR_WIDTH(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_ser_clk(ser_clk),
    .i_ser_latch(ser_latch),
    .i_ser_mosi(ser_mosi),
    .i_wb_cyc(wb_cyc),
    .i_wb_stb(wb_stb),
    .i_wb_we(wb_we),
    .i_wb_addr(wb_addr),
    .i_wb_sel(wb_sel),
    .i_wb_wdata(wb_wdata),
    .o_wb_ack(wb_ack),
    .o_wb_stall(wb_stall),
    .o_wb_rdata(wb_rdata),
    .o_frame_strobe(frame_strobe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_strobe) strobe_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [3:0] addr, input logic [3:0] sel,
                         input logic [31:0] wdata, output logic [31:0] rdata);
    int n;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = addr; wb_sel = sel; wb_wdata = wdata;
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    n = 0;
    while (!wb_ack && n < 4) begin
      @(negedge clk);
      n++;
    end
    rdata = wb_rdata;
    if (!wb_ack) check("wb_ack_timeout", 32'(wb_ack), 32'd1);
    @(negedge clk);
  endtask

  task automatic rd_check(input string name, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    wb_xfer(1'b0, addr, 4'h0, 32'h0, d);
    check(name, d, exp);
  endtask

  task automatic run_table(input string name, input int n);
    for (int i = 0; i < n; i++) rd_check($sformatf("%s[addr%0d]", name, tbl[i].addr),
                                         tbl[i].addr, tbl[i].exp);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      ser_mosi = w[31-i];
      repeat (4) @(negedge clk);
      ser_clk = 1'b1;
      repeat (4) @(negedge clk);
      ser_clk = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_latch();
    ser_latch = 1'b1;
    repeat (4) @(negedge clk);
    ser_latch = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_bits(w, 32);
    pulse_latch();
  endtask

  function automatic logic [31:0] blank(input int r);
    return 32'hFFFFFF00 | (32'h80 >> r);
  endfunction

  task automatic blank_rows(input int from, input int to);
    for (int r = from; r <= to; r++) send_word(blank(r));
  endtask

  initial begin
    logic [31:0] d;
    reset = 1'b1;
    ser_clk = 1'b0; ser_latch = 1'b0; ser_mosi = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_addr = '0; wb_sel = '0; wb_wdata = '0;
    repeat (5) @(negedge clk);
    check("reset_ack", 32'(wb_ack), 32'd0);
    check("reset_strobe", 32'(frame_strobe), 32'd0);
    check("reset_rdata", wb_rdata, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    rd_check("reset_status", 4'd8, 32'h0);
    rd_check("reset_row0", 4'd0, 32'h0);

    // Image capture: 3 frames, red col0 on every row.
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < 8; r++) begin
        send_word(32'h7FFFFF00 | (32'h80 >> r));
        if (f == 2 && r == 6) check("strobe_before_24", 32'(strobe_cnt), 32'd0);
      end
    end
    check("strobe_after_24", 32'(strobe_cnt), 32'd1);
    for (int i = 0; i < 8; i++) tbl[i] = '{addr: 4'(i), exp: 32'h40000000};
    tbl[8]  = '{addr: 4'd8,  exp: 32'h00030000};
    tbl[9]  = '{addr: 4'd9,  exp: 32'h0};
    tbl[10] = '{addr: 4'd13, exp: 32'h0};
    run_table("image", 11);

    // RGB over 3 frames on row 2, col 0.
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < 8; r++) begin
        if (r == 2) begin
          case (f)
            0:       send_word(32'h7FFFFF20);
            1:       send_word(32'hFF7FFF20);
            default: send_word(32'hFFFF7F20);
          endcase
        end else begin
          send_word(blank(r));
        end
      end
    end
    check("strobe_rgb", 32'(strobe_cnt), 32'd2);
    for (int i = 0; i < 8; i++) tbl[i] = '{addr: 4'(i), exp: (i == 2) ? 32'h70000000 : 32'h0};
    tbl[8] = '{addr: 4'd8, exp: 32'h00060000};
    run_table("rgb", 9);

    // Short word: 31 shifts then latch.
    send_bits(32'h7FFFFF80, 31);
    pulse_latch();
    rd_check("short_word_status", 4'd8, 32'h00060001);
    send_word(32'h7FFFFF80);
    // Bad anodes.
    send_word(32'hFFFFFF00);
    send_word(32'hFFFFFF81);
    rd_check("bad_anode_status", 4'd8, 32'h00060201);
    // Collision: a 33rd shift edge coincides with the latch edge.
    send_bits(32'hFFFFFE40, 32);
    ser_mosi = 1'b1;
    ser_clk = 1'b1; ser_latch = 1'b1;
    repeat (4) @(negedge clk);
    ser_clk = 1'b0; ser_latch = 1'b0;
    repeat (6) @(negedge clk);
    rd_check("collision_status", 4'd8, 32'h00060201);
    blank_rows(2, 7);
    blank_rows(0, 7);
    blank_rows(0, 7);
    check("strobe_err_frames", 32'(strobe_cnt), 32'd3);
    for (int i = 0; i < 8; i++) tbl[i] = '{addr: 4'(i), exp: 32'h0};
    tbl[0].exp = 32'h40000000;
    tbl[1].exp = 32'h00000002;
    tbl[8] = '{addr: 4'd8, exp: 32'h00090201};
    run_table("errs", 9);

    // CTRL: partial frame with row3 red, then clear.
    blank_rows(0, 2);
    send_word(32'h7FFFFF10);
    wb_xfer(1'b1, 4'd9, 4'hE, 32'h1, d);
    rd_check("ctrl_nosel_status", 4'd8, 32'h00090201);
    wb_xfer(1'b1, 4'd9, 4'h1, 32'h1, d);
    rd_check("ctrl_clear_status", 4'd8, 32'h00090000);
    rd_check("ctrl_read9", 4'd9, 32'h0);
    blank_rows(4, 7);
    blank_rows(0, 7);
    check("strobe_ctrl_2frames", 32'(strobe_cnt), 32'd3);
    rd_check("ctrl_row0_held", 4'd0, 32'h40000000);
    blank_rows(0, 7);
    check("strobe_ctrl_3frames", 32'(strobe_cnt), 32'd4);
    for (int i = 0; i < 8; i++) tbl[i] = '{addr: 4'(i), exp: 32'h0};
    tbl[8] = '{addr: 4'd8, exp: 32'h000C0000};
    run_table("ctrl", 9);

    // Reset mid-word.
    send_bits(32'hAAAAAAAA, 17);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("midreset_ack", 32'(wb_ack), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    rd_check("midreset_status", 4'd8, 32'h0);
    rd_check("midreset_row1", 4'd1, 32'h0);
    send_word(32'h7FFFFF01);
    rd_check("post_reset_word", 4'd8, 32'h00010000);
    check("post_reset_strobe", 32'(strobe_cnt), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
